// File: rtl/led_pkg.sv
// led_pkg: shared register map and bus helpers
// for the LED PWM driver slice.
package led_pkg;

  localparam logic [1:0] LED_PATTERN = 2'd0;
  localparam logic [1:0] LED_BLINK   = 2'd1;
  localparam logic [1:0] LED_DUTY    = 2'd2;
  localparam logic [1:0] LED_PERIOD  = 2'd3;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/led_timebase.sv
// led_timebase: free-running PWM counter plus
// blink prescaler and phase with restart on write.
module led_timebase
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         period,
  input  logic                period_wr,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on,
  output logic                phase
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [31:0]         presc;

  // PWM counter wraps naturally from all-ones to 0
  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  // blink prescaler; a PERIOD write beats terminal count
  always_ff @(posedge clk) begin
    if (reset || period_wr || period == 32'd0) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (presc == period - 32'd1) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  assign pwm_on = (duty == '1) || (pwm_cnt < duty);

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: bridge slave with pattern, blink,
// duty and period registers driving active-low LEDs.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int          N_LED     = 32,
  parameter int          PWM_BITS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE,
  input  logic [3:0]       BE,
  input  logic [31:0]      Addr,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [N_LED-1:0] led_light
);

  logic [N_LED-1:0]    pattern;
  logic [N_LED-1:0]    blink;
  logic [PWM_BITS-1:0] duty;
  logic [31:0]         period;

  logic [31:0] pattern_ext, blink_ext, duty_ext;
  logic [31:0] pattern_nxt, blink_nxt, duty_nxt;
  logic [31:0] period_nxt;

  logic             cs, wr, period_wr;
  logic [1:0]       idx;
  logic             pwm_on, phase;
  logic [N_LED-1:0] lit;
  logic             unused_bits;

  assign cs  = (Addr[31:4] == BASE_ADDR[31:4]);
  assign idx = Addr[3:2];
  assign wr  = WE & cs;
  assign period_wr = wr & (idx == LED_PERIOD) & (|BE);

  // zero-extend registers to bus width
  always_comb begin
    pattern_ext = '0;
    blink_ext   = '0;
    duty_ext    = '0;
    pattern_ext[N_LED-1:0]  = pattern;
    blink_ext[N_LED-1:0]    = blink;
    duty_ext[PWM_BITS-1:0]  = duty;
  end

  // byte-enable merged candidate values
  always_comb begin
    pattern_nxt = be_merge(pattern_ext, Din, BE);
    blink_nxt   = be_merge(blink_ext, Din, BE);
    duty_nxt    = be_merge(duty_ext, Din, BE);
    period_nxt  = be_merge(period, Din, BE);
  end

  // register file; reset overrides any write
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= '0;
      blink   <= '0;
      duty    <= '0;
      period  <= '0;
    end else if (wr) begin
      case (idx)
        LED_PATTERN: pattern <= pattern_nxt[N_LED-1:0];
        LED_BLINK:   blink   <= blink_nxt[N_LED-1:0];
        LED_DUTY:    duty    <= duty_nxt[PWM_BITS-1:0];
        default:     period  <= period_nxt;
      endcase
    end
  end

  // read mux ignores chip select
  always_comb begin
    Dout = '0;
    case (idx)
      LED_PATTERN: Dout = pattern_ext;
      LED_BLINK:   Dout = blink_ext;
      LED_DUTY:    Dout = duty_ext;
      default:     Dout = period;
    endcase
  end

  led_timebase #(
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk       (clk),
    .reset     (reset),
    .period    (period),
    .period_wr (period_wr),
    .duty      (duty),
    .pwm_on    (pwm_on),
    .phase     (phase)
  );

  assign lit = pattern & {N_LED{pwm_on}} & (~blink | {N_LED{phase}});

  // single active-low output register stage
  always_ff @(posedge clk) begin
    if (reset) led_light <= '1;
    else       led_light <= ~lit;
  end

  assign unused_bits = ^{Addr[1:0], pattern_nxt, blink_nxt, duty_nxt};

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: randomized and directed bench
// against a cycle-count based behavioural model.
module tb_led_pwm_driver;

  localparam logic [31:0] BASE = 32'h0000_7f50;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] Addr;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [31:0] led_light;

  int checks = 0;
  int errors = 0;

  led_pwm_driver dut (
    .clk       (clk),
    .reset     (reset),
    .WE        (WE),
    .BE        (BE),
    .Addr      (Addr),
    .Din       (Din),
    .Dout      (Dout),
    .led_light (led_light)
  );

  always #5 clk = ~clk;

  // behavioural model: time since reset and since blink restart
  logic [31:0] m_pat, m_blk, m_per;
  logic [7:0]  m_duty;
  int unsigned cyc;
  int unsigned s;
  logic [31:0] exp_led;
  logic [31:0] half_cycles;
  logic        pwm_now, phase_now;

  function automatic logic [31:0] merge(
    input logic [31:0] o, input logic [31:0] n, input logic [3:0] b
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] i);
    case (i)
      2'd0:    return m_pat;
      2'd1:    return m_blk;
      2'd2:    return {24'd0, m_duty};
      default: return m_per;
    endcase
  endfunction

  assign pwm_now = (m_duty == 8'hFF) || (cyc[7:0] < m_duty);
  assign half_cycles = (m_per == 32'd0) ? 32'd0 : s / m_per;
  assign phase_now = (m_per == 32'd0) || (half_cycles[0] == 1'b0);

  always @(posedge clk) begin
    if (reset) begin
      m_pat   <= '0;
      m_blk   <= '0;
      m_per   <= '0;
      m_duty  <= '0;
      cyc     <= 0;
      s       <= 0;
      exp_led <= '1;
    end else begin
      exp_led <= ~(m_pat & {32{pwm_now}} & (~m_blk | {32{phase_now}}));
      cyc <= cyc + 1;
      s <= s + 1;
      if (WE && Addr[31:4] == BASE[31:4]) begin
        case (Addr[3:2])
          2'd0: m_pat <= merge(m_pat, Din, BE);
          2'd1: m_blk <= merge(m_blk, Din, BE);
          2'd2: if (BE[0]) m_duty <= Din[7:0];
          default: begin
            m_per <= merge(m_per, Din, BE);
            if (BE != 4'd0) s <= 0;
          end
        endcase
      end
    end
  end

  task automatic wr(
    input logic [31:0] a, input logic [31:0] d, input logic [3:0] b
  );
    @(negedge clk);
    WE = 1'b1; Addr = a; Din = d; BE = b;
    @(negedge clk);
    WE = 1'b0; BE = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Addr = BASE + 32'(4 * i);
      #1;
      checks++;
      if (Dout !== 32'd0) begin
        errors++;
        $display("FAIL reset_dout[%0d]: got %h expected 0", i, Dout);
      end
    end
    checks++;
    if (led_light !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_led: got %h expected ffffffff", led_light);
    end
  endtask

  task automatic test_byte_enable();
    wr(BASE + 32'h8, 32'hABCD_12FF, 4'hF);
    Addr = BASE + 32'h8;
    #1;
    checks++;
    if (Dout !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL duty_width: got %h expected 000000ff", Dout);
    end
    wr(BASE, 32'h1234_5678, 4'b0101);
    Addr = BASE;
    #1;
    checks++;
    if (Dout !== 32'h0034_0078) begin
      errors++;
      $display("FAIL be_pattern: got %h expected 00340078", Dout);
    end
    @(negedge clk);
    checks++;
    if (led_light !== ~32'h0034_0078 || led_light !== exp_led) begin
      errors++;
      $display("FAIL be_led: got %h expected %h", led_light, ~32'h0034_0078);
    end
  endtask

  task automatic test_pwm();
    int lows;
    logic [7:0] c;
    logic exp_low;
    do_reset();
    wr(BASE + 32'h8, 32'h40, 4'h1);
    wr(BASE, 32'h1, 4'hF);
    lows = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      c = cyc[7:0] - 8'd1;
      exp_low = (c < 8'd64);
      if (!led_light[0]) lows++;
      checks++;
      if (led_light[0] !== ~exp_low || led_light !== exp_led) begin
        errors++;
        $display("FAIL pwm_cycle cnt=%0d: got %h expected %h",
                 c, led_light, exp_led);
      end
    end
    checks++;
    if (lows != 64) begin
      errors++;
      $display("FAIL pwm_low_count: got %0d expected 64", lows);
    end
  endtask

  task automatic test_blink();
    logic e;
    do_reset();
    wr(BASE + 32'h8, 32'hFF, 4'h1);
    wr(BASE, 32'h8, 4'hF);
    wr(BASE + 32'h4, 32'h8, 4'hF);
    wr(BASE + 32'hC, 32'd5, 4'hF);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      e = (i <= 5) ? 1'b0 : 1'b1;
      checks++;
      if (led_light[3] !== e || led_light !== exp_led) begin
        errors++;
        $display("FAIL blink_run[%0d]: got %h expected bit3=%b model %h",
                 i, led_light, e, exp_led);
      end
    end
    wr(BASE + 32'hC, 32'd5, 4'h1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      e = (i <= 5) ? 1'b0 : 1'b1;
      checks++;
      if (led_light[3] !== e || led_light !== exp_led) begin
        errors++;
        $display("FAIL blink_restart[%0d]: got %h expected bit3=%b model %h",
                 i, led_light, e, exp_led);
      end
    end
  endtask

  task automatic test_ignored_writes();
    logic [31:0] snap [4];
    for (int i = 0; i < 4; i++) snap[i] = m_read(2'(i));
    wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(BASE, 32'hFFFF_FFFF, 4'h0);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'h0);
    wr(BASE - 32'h10 + 32'h4, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      Addr = BASE + 32'(4 * i);
      #1;
      checks++;
      if (Dout !== snap[i] || Dout !== m_read(2'(i))) begin
        errors++;
        $display("FAIL ignored_write[%0d]: got %h expected %h",
                 i, Dout, snap[i]);
      end
    end
    Addr = BASE + 32'h10;
    #1;
    checks++;
    if (Dout !== snap[0]) begin
      errors++;
      $display("FAIL read_no_cs: got %h expected %h", Dout, snap[0]);
    end
  endtask

  task automatic test_random();
    logic [1:0] ri;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      checks++;
      if (led_light !== exp_led) begin
        errors++;
        $display("FAIL rand_led @%0d: got %h expected %h",
                 n, led_light, exp_led);
      end
      checks++;
      if (Dout !== m_read(Addr[3:2])) begin
        errors++;
        $display("FAIL rand_dout @%0d: got %h expected %h",
                 n, Dout, m_read(Addr[3:2]));
      end
      reset = ($urandom_range(0, 199) == 0);
      WE = ($urandom_range(0, 2) == 0);
      ri = 2'($urandom_range(0, 3));
      Addr = BASE + {28'd0, ri, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) Addr = Addr + 32'h10;
      BE = 4'($urandom_range(0, 15));
      case (ri)
        2'd3: Din = $urandom_range(0, 12);
        2'd2: begin
          case ($urandom_range(0, 3))
            0: Din = 32'h0;
            1: Din = 32'hFF;
            default: Din = $urandom;
          endcase
        end
        default: Din = $urandom;
      endcase
    end
    @(negedge clk);
    reset = 1'b0;
    WE = 1'b0;
    BE = 4'd0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(BASE + 32'h8, 32'hFF, 4'h1);
    wr(BASE, 32'hFF, 4'hF);
    wr(BASE + 32'h4, 32'hFF, 4'hF);
    wr(BASE + 32'hC, 32'd5, 4'hF);
    repeat (7) @(negedge clk);
    checks++;
    if (led_light[3] !== 1'b1) begin
      errors++;
      $display("FAIL mid_dark: got %b expected 1", led_light[3]);
    end
    reset = 1'b1;
    WE = 1'b1; Addr = BASE; Din = 32'hFFFF_FFFF; BE = 4'hF;
    @(negedge clk);
    reset = 1'b0;
    WE = 1'b0; BE = 4'd0;
    for (int i = 0; i < 4; i++) begin
      Addr = BASE + 32'(4 * i);
      #1;
      checks++;
      if (Dout !== 32'd0) begin
        errors++;
        $display("FAIL mid_reset_dout[%0d]: got %h expected 0", i, Dout);
      end
    end
    checks++;
    if (led_light !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL mid_reset_led: got %h expected ffffffff", led_light);
    end
  endtask

  initial begin
    reset = 1'b1;
    WE = 1'b0;
    BE = 4'd0;
    Addr = '0;
    Din = '0;
    test_reset();
    test_byte_enable();
    test_pwm();
    test_blink();
    test_ignored_writes();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
